// File: rtl/clk_div_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the multi-channel programmable clock divider:
// channel state encoding, default divisor values and a helper that sizes
// the channel-select field.
// ---------------------------------------------------------------------------
package clk_div_pkg;

  // Per-channel control state
  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } ch_state_e;

  // Reset half-period minus 1: 50 MHz -> 500 Hz output in silicon
  localparam int unsigned DEF_DIV_SYN = 32'd49_999;
  // Short default for simulation builds
  localparam int unsigned DEF_DIV_SIM = 32'd25;

  // Width of a field able to address n channels (at least one bit)
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// ---------------------------------------------------------------------------
// clk_div_chan
// One divider channel: run/stop/single-step FSM, half-period counter,
// shadow and active divisor registers, registered clock/tick outputs.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   wr_en    in   load wdata into the shadow divisor
//   wdata    in   new half-period minus 1
//   run      in   free-run level
//   step     in   single-step request (1-cycle pulse)
//   clk_out  out  divided clock (registered)
//   tick     out  1-cycle pulse on the edge clk_out rises (registered)
//   active   out  channel is not stopped (registered)
// ---------------------------------------------------------------------------
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned DEF_DIV = DEF_DIV_SYN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wdata,
  input  logic             run,
  input  logic             step,
  output logic             clk_out,
  output logic             tick,
  output logic             active
);

  localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);

  ch_state_e        state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] div_act_r, div_act_s;
  logic [CNT_W-1:0] div_shd_r, div_shd_s;
  logic             clk_r, clk_s;
  logic             tick_r, tick_s;
  logic             active_r;
  logic             toggle_s;

  // Half-period reached: the counter never passes div_act, so >= is a safe terminal test
  assign toggle_s = (cnt_r >= div_act_r);

  // Next-state, counter and divisor logic
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    clk_s     = clk_r;
    tick_s    = 1'b0;
    div_act_s = div_act_r;
    // A write landing on a toggle edge is seen by the following toggle
    if (wr_en) begin
      div_shd_s = wdata;
    end else begin
      div_shd_s = div_shd_r;
    end
    case (state_r)
      ST_STOP: begin
        cnt_s     = '0;
        clk_s     = 1'b0;
        div_act_s = div_shd_r;
        if (run) begin
          state_s = ST_RUN;
        end else if (step) begin
          state_s = ST_STEP;
        end else begin
          state_s = ST_STOP;
        end
      end
      ST_RUN: begin
        if (!run && !clk_r) begin
          // Stopping during the low phase is immediate; the output is already low
          state_s = ST_STOP;
          cnt_s   = '0;
        end else if (toggle_s) begin
          cnt_s     = '0;
          clk_s     = ~clk_r;
          tick_s    = ~clk_r;
          div_act_s = div_shd_r;
          // A high phase is never cut short: run=0 is honoured on the falling toggle
          if (clk_r && !run) begin
            state_s = ST_STOP;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_STEP: begin
        if (toggle_s) begin
          cnt_s     = '0;
          clk_s     = ~clk_r;
          tick_s    = ~clk_r;
          div_act_s = div_shd_r;
          // One full period done on the falling toggle; run is only looked at here
          if (clk_r) begin
            state_s = run ? ST_RUN : ST_STOP;
          end else begin
            state_s = ST_STEP;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = ST_STOP;
        cnt_s   = '0;
        clk_s   = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_STOP;
      cnt_r     <= '0;
      clk_r     <= 1'b0;
      tick_r    <= 1'b0;
      active_r  <= 1'b0;
      div_act_r <= DEF_DIV_C;
      div_shd_r <= DEF_DIV_C;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      clk_r     <= clk_s;
      tick_r    <= tick_s;
      active_r  <= (state_s != ST_STOP);
      div_act_r <= div_act_s;
      div_shd_r <= div_shd_s;
    end
  end

  assign clk_out = clk_r;
  assign tick    = tick_r;
  assign active  = active_r;

endmodule

// File: rtl/clk_div_multi.sv
// ---------------------------------------------------------------------------
// clk_div_multi
// N-channel programmable clock divider. Each channel produces a square
// clock and a one-cycle tick, with run/stop/single-step control and a
// runtime-loadable half-period.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   div_wr     in   divisor write strobe
//   div_sel    in   channel addressed by div_wr (out-of-range ignored)
//   div_wdata  in   new half-period minus 1
//   run        in   per-channel free-run level
//   step       in   per-channel single-step pulse
//   clk_out    out  per-channel divided clock
//   tick       out  per-channel rising-edge pulse
//   active     out  per-channel not-stopped flag
// ---------------------------------------------------------------------------
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned DEF_DIV = DEF_DIV_SYN,
  localparam int unsigned CH_W   = ch_width(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_wr,
  input  logic [CH_W-1:0]  div_sel,
  input  logic [CNT_W-1:0] div_wdata,
  input  logic [N_CH-1:0]  run,
  input  logic [N_CH-1:0]  step,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  active
);

  logic [N_CH-1:0] wr_en_s;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    // Exact-match decode: selects at or above N_CH match no channel
    assign wr_en_s[g] = div_wr & (div_sel == CH_W'(g));

    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en_s[g]),
      .wdata   (div_wdata),
      .run     (run[g]),
      .step    (step[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g]),
      .active  (active[g])
    );
  end

endmodule
